// File: rtl/hier_signature_collector.sv
// rtl/hier_signature_collector.sv - N_CHILD self-seeded LFSR channels, run then drained in index order
module hier_signature_collector #(
    parameter int               N_CHILD    = 5,
    parameter int               WIDTH      = 16,
    parameter logic [WIDTH-1:0] POLY       = 16'h1021,
    parameter int               RUN_CYCLES = 64,
    parameter int               IDX_W      = (N_CHILD > 1) ? $clog2(N_CHILD) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             sig_valid_o,
    input  logic             sig_ready_i,
    output logic [WIDTH-1:0] sig_data_o,
    output logic [IDX_W-1:0] sig_idx_o,
    output logic             sig_last_o
);

    localparam int CNT_W = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sig_q [N_CHILD];
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             run_last;
    logic             idx_last;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s,
                                                   input logic [WIDTH-1:0] k);
        return {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0) ^ k;
    endfunction

    assign run_last = (cnt == CNT_W'(RUN_CYCLES - 1));
    assign idx_last = (idx == IDX_W'(N_CHILD - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start_i) state_nxt = S_RUN;
            S_RUN:   if (run_last) state_nxt = S_DRAIN;
            S_DRAIN: if (sig_ready_i && idx_last) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Channels only move in RUN; seeding happens on the accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
            for (int k = 0; k < N_CHILD; k++) begin
                sig_q[k] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        cnt <= '0;
                        for (int k = 0; k < N_CHILD; k++) begin
                            sig_q[k] <= WIDTH'(k + 1);
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    for (int k = 0; k < N_CHILD; k++) begin
                        sig_q[k] <= lfsr_step(sig_q[k], WIDTH'(k));
                    end
                end
                S_DRAIN: begin
                    if (sig_ready_i) begin
                        idx <= idx_last ? '0 : idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // idx rests at 0 outside DRAIN, so the mux presents s_0 there.
    assign busy_o      = (state == S_RUN) || (state == S_DRAIN);
    assign done_o      = (state == S_DONE);
    assign sig_valid_o = (state == S_DRAIN);
    assign sig_last_o  = (state == S_DRAIN) && idx_last;
    assign sig_idx_o   = idx;
    assign sig_data_o  = sig_q[idx];

endmodule

// File: tb/tb_hier_signature_collector.sv
// tb/tb_hier_signature_collector.sv - directed vectors and model-checked runs for hier_signature_collector
module tb_hier_signature_collector;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] start_v = '0;
    logic [4:0] ready_v = '0;
    wire  [4:0] busy_v, done_v, valid_v, last_v;

    wire [7:0]  data_a;
    wire [15:0] data_b;
    wire [1:0]  data_c;
    wire [31:0] data_d;
    wire [1:0]  data_e;
    wire        idx_a;
    wire [2:0]  idx_b;
    wire        idx_c;
    wire [2:0]  idx_d;
    wire [3:0]  idx_e;

    logic [31:0] data_v [5];
    logic [31:0] idx_v  [5];

    int          cfg_n    [5] = '{2, 5, 1, 7, 16};
    int          cfg_w    [5] = '{8, 16, 2, 32, 2};
    int          cfg_rc   [5] = '{1, 64, 1, 200, 200};
    logic [31:0] cfg_poly [5] = '{32'h1D, 32'h1021, 32'h3, 32'h04C11DB7, 32'h3};

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        data_v[0] = 32'(data_a);
        data_v[1] = 32'(data_b);
        data_v[2] = 32'(data_c);
        data_v[3] = data_d;
        data_v[4] = 32'(data_e);
        idx_v[0]  = 32'(idx_a);
        idx_v[1]  = 32'(idx_b);
        idx_v[2]  = 32'(idx_c);
        idx_v[3]  = 32'(idx_d);
        idx_v[4]  = 32'(idx_e);
    end

    hier_signature_collector #(.N_CHILD(2), .WIDTH(8), .POLY(8'h1D), .RUN_CYCLES(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[0]), .busy_o(busy_v[0]), .done_o(done_v[0]),
        .sig_valid_o(valid_v[0]), .sig_ready_i(ready_v[0]), .sig_data_o(data_a),
        .sig_idx_o(idx_a), .sig_last_o(last_v[0]));

    hier_signature_collector u_b (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[1]), .busy_o(busy_v[1]), .done_o(done_v[1]),
        .sig_valid_o(valid_v[1]), .sig_ready_i(ready_v[1]), .sig_data_o(data_b),
        .sig_idx_o(idx_b), .sig_last_o(last_v[1]));

    hier_signature_collector #(.N_CHILD(1), .WIDTH(2), .POLY(2'h3), .RUN_CYCLES(1)) u_c (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[2]), .busy_o(busy_v[2]), .done_o(done_v[2]),
        .sig_valid_o(valid_v[2]), .sig_ready_i(ready_v[2]), .sig_data_o(data_c),
        .sig_idx_o(idx_c), .sig_last_o(last_v[2]));

    hier_signature_collector #(.N_CHILD(7), .WIDTH(32), .POLY(32'h04C11DB7), .RUN_CYCLES(200)) u_d (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[3]), .busy_o(busy_v[3]), .done_o(done_v[3]),
        .sig_valid_o(valid_v[3]), .sig_ready_i(ready_v[3]), .sig_data_o(data_d),
        .sig_idx_o(idx_d), .sig_last_o(last_v[3]));

    hier_signature_collector #(.N_CHILD(16), .WIDTH(2), .POLY(2'h3), .RUN_CYCLES(200)) u_e (
        .clk(clk), .rst_n(rst_n), .start_i(start_v[4]), .busy_o(busy_v[4]), .done_o(done_v[4]),
        .sig_valid_o(valid_v[4]), .sig_ready_i(ready_v[4]), .sig_data_o(data_e),
        .sig_idx_o(idx_e), .sig_last_o(last_v[4]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Software LFSR: seed k+1, RUN_CYCLES steps of shift/feedback/xor k, all masked to WIDTH.
    function automatic logic [31:0] model_sig(input int i, input int k);
        logic [31:0] mask, s, kk;
        logic        msb;
        mask = (cfg_w[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cfg_w[i]) - 32'd1);
        s    = 32'(k + 1) & mask;
        kk   = 32'(k) & mask;
        for (int c = 0; c < cfg_rc[i]; c++) begin
            msb = s[cfg_w[i] - 1];
            s   = ((s << 1) ^ (msb ? cfg_poly[i] : 32'd0) ^ kk) & mask;
        end
        return s;
    endfunction

    // Entered and left on a falling edge with the instance idle.
    task automatic run_check(input int i, input int stall_at, input int stall_len, input bit keep);
        int cyc, got, stalled, n, rc;
        bit acc;
        n  = cfg_n[i];
        rc = cfg_rc[i];
        start_v[i] = 1'b1;
        ready_v[i] = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) start_v[i] = 1'b0;
        @(negedge clk);
        cyc = 1;
        chk($sformatf("run_busy[%0d]", i), 32'(busy_v[i]), 32'd1);
        chk($sformatf("run_valid[%0d]", i), 32'(valid_v[i]), 32'd0);
        while (!valid_v[i] && cyc <= rc + 4) begin
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("first_valid_cycle[%0d]", i), 32'(cyc), 32'(rc + 1));
        got = 0;
        stalled = 0;
        while (got < n && cyc <= rc + n + stall_len + 8) begin
            chk($sformatf("valid[%0d].%0d", i, got), 32'(valid_v[i]), 32'd1);
            chk($sformatf("idx[%0d].%0d", i, got), idx_v[i], 32'(got));
            chk($sformatf("data[%0d].%0d", i, got), data_v[i], model_sig(i, got));
            chk($sformatf("last[%0d].%0d", i, got), 32'(last_v[i]), 32'(got == n - 1));
            if (got == n - 1 && stall_len == 0)
                chk($sformatf("last_cycle[%0d]", i), 32'(cyc), 32'(rc + n));
            if (got == stall_at && stalled < stall_len) begin
                ready_v[i] = 1'b0;
                stalled++;
                acc = 1'b0;
            end else begin
                ready_v[i] = 1'b1;
                acc = 1'b1;
            end
            @(negedge clk);
            cyc++;
            if (acc) got++;
        end
        chk($sformatf("drain_count[%0d]", i), 32'(got), 32'(n));
        chk($sformatf("done_pulse[%0d]", i), 32'(done_v[i]), 32'd1);
        chk($sformatf("done_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
        chk($sformatf("done_valid[%0d]", i), 32'(valid_v[i]), 32'd0);
        @(negedge clk);
        chk($sformatf("idle_done[%0d]", i), 32'(done_v[i]), 32'd0);
        chk($sformatf("idle_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
        chk($sformatf("idle_valid[%0d]", i), 32'(valid_v[i]), 32'd0);
        chk($sformatf("idle_idx[%0d]", i), idx_v[i], 32'd0);
        chk($sformatf("idle_data_s0[%0d]", i), data_v[i], model_sig(i, 0));
    endtask

    typedef struct {
        logic       start;
        logic       ready;
        logic       busy;
        logic       done;
        logic       valid;
        logic [7:0] idx;
        logic [7:0] data;
        logic       last;
    } vec_t;

    vec_t tv [13];

    initial begin
        // Each row: expected outputs at this falling edge, then inputs for the next rising edge.
        tv[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b0};
        tv[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'h01, 1'b0};
        tv[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'h02, 1'b0};
        tv[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 8'h05, 1'b1};
        tv[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h02, 1'b0};
        tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h02, 1'b0};
        tv[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'h01, 1'b0};
        tv[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, 8'h02, 1'b0};
        tv[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, 8'h02, 1'b0};
        tv[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, 8'h05, 1'b1};
        tv[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, 8'h05, 1'b1};
        tv[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'h02, 1'b0};
        tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h02, 1'b0};

        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
            chk($sformatf("rst_done[%0d]", i), 32'(done_v[i]), 32'd0);
            chk($sformatf("rst_valid[%0d]", i), 32'(valid_v[i]), 32'd0);
            chk($sformatf("rst_last[%0d]", i), 32'(last_v[i]), 32'd0);
            chk($sformatf("rst_idx[%0d]", i), idx_v[i], 32'd0);
            chk($sformatf("rst_data[%0d]", i), data_v[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 13; r++) begin
            chk($sformatf("tv%0d_busy", r), 32'(busy_v[0]), 32'(tv[r].busy));
            chk($sformatf("tv%0d_done", r), 32'(done_v[0]), 32'(tv[r].done));
            chk($sformatf("tv%0d_valid", r), 32'(valid_v[0]), 32'(tv[r].valid));
            chk($sformatf("tv%0d_idx", r), idx_v[0], 32'(tv[r].idx));
            chk($sformatf("tv%0d_data", r), data_v[0], 32'(tv[r].data));
            chk($sformatf("tv%0d_last", r), 32'(last_v[0]), 32'(tv[r].last));
            start_v[0] = tv[r].start;
            ready_v[0] = tv[r].ready;
            @(negedge clk);
        end

        run_check(1, 2, 10, 1'b0);

        start_v[1] = 1'b1;
        @(posedge clk);
        #1;
        start_v[1] = 1'b0;
        repeat (30) @(negedge clk);
        chk("midrun_busy", 32'(busy_v[1]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy_v[1]), 32'd0);
        chk("abort_valid", 32'(valid_v[1]), 32'd0);
        chk("abort_data", data_v[1], 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", 32'(valid_v[1]), 32'd0);
        chk("post_rst_busy", 32'(busy_v[1]), 32'd0);
        run_check(1, 0, 0, 1'b0);

        run_check(1, 0, 0, 1'b1);
        run_check(1, 3, 2, 1'b1);
        start_v[1] = 1'b0;
        @(negedge clk);
        chk("no_third_run", 32'(busy_v[1]), 32'd0);

        run_check(2, 0, 0, 1'b0);
        run_check(3, 0, 0, 1'b0);
        run_check(3, 6, 3, 1'b0);
        run_check(4, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
